sh7604_ibus_xfer_master: RTL and testbench
==========================================

Name: sh7604_ibus_xfer_master

Overview:
- Single-channel internal-bus initiator. It performs memory-to-memory block copies by issuing paired read and write accesses on the IBUS.
- It drives the initiator side of the protocol that on-chip peripheral register blocks respond to.
- It sits beside the CPU core as an IBUS master candidate. Any responder can be its target: peripheral register files, on-chip RAM, or the bus bridge.
- Control comes from a parent register block through direct START, address, count and size inputs.

Parameters:
- CNT_W, 24, transfer-count width. A programmed count of 0 means 2^CNT_W transfers.

Ports:
- CLK  in  1  system clock. One clock only.
- RST  in  1  reset, synchronous, active-high.
- CE_R  in  1  rising-phase clock enable. All state advances, request launches and completions are qualified by this.
- CE_F  in  1  falling-phase clock enable. Unused internally; present for uniformity with other IBUS blocks.
- START  in  1  launch request. Sampled on CE_R while IDLE.
- SRC_ADDR  in  32  source start address. Latched at START.
- DST_ADDR  in  32  destination start address. Latched at START.
- SRC_INC  in  1  1 = increment source address by the size after each transfer; 0 = fixed.
- DST_INC  in  1  same rule for the destination address.
- SIZE  in  2  transfer size: 00 byte, 01 word, 10 long, 11 reserved (treated as long).
- COUNT  in  CNT_W  number of transfers.
- IE  in  1  interrupt enable.
- ABORT  in  1  stop request.
- IBUS_A  out  32  access address.
- IBUS_DO  out  32  write data.
- IBUS_DI  in  32  read data from the responder.
- IBUS_BA  out  4  byte-lane enables. Bit 3 = bits [31:24], big-endian.
- IBUS_WE  out  1  1 = write.
- IBUS_REQ  out  1  access request.
- IBUS_BUSY  in  1  responder stall.
- ACTIVE  out  1  engine is in RD or WR.
- DONE  out  1  sticky completion flag.
- ADDR_ERR  out  1  sticky misalignment flag.
- ABORTED  out  1  sticky abort flag.
- IRQ  out  1  interrupt, equal to IE & (DONE | ADDR_ERR).

Behaviour:
- Reset values: IBUS_A=0, IBUS_DO=0, IBUS_BA=0, IBUS_WE=0, IBUS_REQ=0, ACTIVE=0, DONE=0, ADDR_ERR=0, ABORTED=0. Internal SAR, DAR and count registers are all 0.
- RST takes effect on the next CLK edge regardless of CE_R. It takes effect even in the middle of an access, dropping IBUS_REQ immediately.
- FSM states are IDLE, RD, WR. Every transition requires CE_R.

IDLE:
- On START, latch SRC_ADDR, DST_ADDR and COUNT, and clear DONE, ADDR_ERR and ABORTED.
- Alignment check: word accesses need address bit 0 = 0; long accesses need bits [1:0] = 0.
- If SRC_ADDR or DST_ADDR is misaligned for SIZE, set ADDR_ERR and stay in IDLE. No bus access is issued.
- Otherwise go to RD.

RD:
- Drive IBUS_REQ=1, IBUS_WE=0, IBUS_A=SAR, IBUS_BA=lane(SAR, SIZE).
- An access completes on a CE_R where IBUS_REQ=1 and IBUS_BUSY=0.
- On completion, capture the selected lane of IBUS_DI into the hold register, right-justified, then go to WR.

WR:
- Drive IBUS_REQ=1, IBUS_WE=1, IBUS_A=DAR, IBUS_BA=lane(DAR, SIZE).
- IBUS_DO carries the hold data replicated across all lanes: byte x4, word x2, long x1.
- On completion:
  - Advance SAR and DAR by 1, 2 or 4 where the matching INC bit is set.
  - Decrement the count modulo 2^CNT_W.
  - If the pre-decrement count was 1, set DONE and go to IDLE. Otherwise go to RD.
- Count 0 therefore runs 2^CNT_W transfers.

Lane map:
- Byte, address [1:0] = 0/1/2/3 → BA = 1000/0100/0010/0001.
- Word, address bit 1 = 0/1 → BA = 1100/0011.
- Long → BA = 1111.

Bus and control rules:
- While IBUS_BUSY=1, hold IBUS_A, IBUS_DO, IBUS_BA and IBUS_WE stable and keep IBUS_REQ asserted. A request is never withdrawn before completion, except by RST.
- ABORT is sampled on CE_R and latched as pending. It takes effect at the next access completion.
  - Completion in RD discards the read data. Completion in WR commits the write and the address/count update.
  - Either way the engine goes to IDLE with ABORTED=1 and DONE=0.
  - ABORT in IDLE has no effect.
- START while in RD or WR is ignored.
- START and ABORT on the same CE_R in IDLE: START wins.
- Address increment wraps modulo 2^32.
- IBUS_REQ=0 in IDLE. IBUS_A, IBUS_BA and IBUS_WE may hold their last values in IDLE.

Test Plan:
- Long copy, SRC=0x06000000, DST=0x06001000, COUNT=3, both INC=1, responder BUSY=0, DI=0x11223344 → six accesses alternating RD/WR. Addresses go 0x06000000 → 0x06001000 → ...04 → ...1004 → ...08 → ...1008. BA=1111 throughout. DONE=1 after the third write; IRQ=1 with IE=1.
- Byte copy, SRC=0xFFFFFF43, DST=0x06000002, COUNT=1, SIZE=00, DI=0xAABBCCDD → read BA=0001, write BA=0010, IBUS_DO=0xDDDDDDDD.
- Stall: BUSY held for 5 CE_R during RD of a word at 0x06000002 → IBUS_REQ, IBUS_A and IBUS_BA (0011) stay stable all 5 cycles. Data is captured only on the BUSY=0 CE_R. Write data is 0x33443344 when DI=0x11223344.
- Misaligned: SIZE=10, SRC=0x06000002, START → ADDR_ERR=1, IBUS_REQ never asserted, ACTIVE=0.
- Abort: COUNT=10, ABORT pulsed during the second WR while BUSY=1 → the write completes, exactly 2 writes total, ABORTED=1, DONE=0, IDLE.
- Reset mid-access: RST during RD with BUSY=1 → next CLK edge gives IBUS_REQ=0 and all flags 0. A new START then runs normally.

Source files
------------

// File: rtl/sh7604_ibus_xfer_master_if.sv
// IBUS initiator/responder signal bundle used by the block-copy master.
interface sh7604_ibus_xfer_master_if;
  logic [31:0] ibus_a;     // access address
  logic [31:0] ibus_do;    // write data (initiator -> responder)
  logic [31:0] ibus_di;    // read data (responder -> initiator)
  logic [3:0]  ibus_ba;    // byte-lane enables, bit 3 = [31:24]
  logic        ibus_we;    // 1 = write
  logic        ibus_req;   // access request
  logic        ibus_busy;  // responder stall

  modport master (
    output ibus_a, ibus_do, ibus_ba, ibus_we, ibus_req,
    input  ibus_di, ibus_busy
  );

  modport slave (
    input  ibus_a, ibus_do, ibus_ba, ibus_we, ibus_req,
    output ibus_di, ibus_busy
  );
endinterface

// File: rtl/sh7604_ibus_xfer_master.sv
// Single-channel IBUS block-copy initiator: alternates a read of SAR with a
// write of DAR for COUNT transfers of byte/word/long size.
module sh7604_ibus_xfer_master #(
  parameter int CNT_W = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ce_r,
  input  logic                 i_ce_f,
  input  logic                 i_start,
  input  logic [31:0]          i_src_addr,
  input  logic [31:0]          i_dst_addr,
  input  logic                 i_src_inc,
  input  logic                 i_dst_inc,
  input  logic [1:0]           i_size,
  input  logic [CNT_W-1:0]     i_count,
  input  logic                 i_ie,
  input  logic                 i_abort,
  sh7604_ibus_xfer_master_if.master ibus,
  output logic                 o_active,
  output logic                 o_done,
  output logic                 o_addr_err,
  output logic                 o_aborted,
  output logic                 o_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Big-endian byte-lane enables for an access of the given size.
  function automatic logic [3:0] f_lane(input logic [1:0] a, input logic [1:0] sz);
    logic [3:0] ba;
    case (sz)
      2'b00: begin
        case (a)
          2'd0:    ba = 4'b1000;
          2'd1:    ba = 4'b0100;
          2'd2:    ba = 4'b0010;
          default: ba = 4'b0001;
        endcase
      end
      2'b01:   ba = a[1] ? 4'b0011 : 4'b1100;
      default: ba = 4'b1111;
    endcase
    return ba;
  endfunction

  // Right-justify the addressed lane(s) of the read data.
  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] a,
                                            input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'b00: begin
        case (a)
          2'd0:    r = {24'd0, d[31:24]};
          2'd1:    r = {24'd0, d[23:16]};
          2'd2:    r = {24'd0, d[15:8]};
          default: r = {24'd0, d[7:0]};
        endcase
      end
      2'b01:   r = a[1] ? {16'd0, d[15:0]} : {16'd0, d[31:16]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Replicate right-justified hold data across every lane of the bus.
  function automatic logic [31:0] f_replicate(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Address stride for one transfer; reserved size behaves as long.
  function automatic logic [31:0] f_step(input logic [1:0] sz);
    logic [31:0] s;
    case (sz)
      2'b00:   s = 32'd1;
      2'b01:   s = 32'd2;
      default: s = 32'd4;
    endcase
    return s;
  endfunction

  // Natural-alignment violation for the given size.
  function automatic logic f_misaligned(input logic [1:0] a, input logic [1:0] sz);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = a[1] | a[0];
    endcase
    return m;
  endfunction

  state_t           r_state;
  logic [31:0]      r_sar;
  logic [31:0]      r_dar;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic             r_src_inc;
  logic             r_dst_inc;
  logic             r_abort_pend;
  logic [31:0]      r_a;
  logic [31:0]      r_do;     // also serves as the hold register during WR
  logic [3:0]       r_ba;
  logic             r_we;
  logic             r_req;
  logic             r_active;
  logic             r_done;
  logic             r_addr_err;
  logic             r_aborted;

  logic             w_xfer;
  logic             w_abort_now;
  logic             w_last;
  logic [31:0]      w_sar_next;
  logic [31:0]      w_dar_next;
  logic [31:0]      w_rd_data;
  logic             w_start_bad;
  logic             w_unused_ok;

  assign w_xfer      = i_ce_r & r_req & ~ibus.ibus_busy;
  assign w_abort_now = r_abort_pend | i_abort;
  assign w_last      = (r_cnt == CNT_ONE);
  assign w_sar_next  = r_src_inc ? (r_sar + f_step(r_size)) : r_sar;
  assign w_dar_next  = r_dst_inc ? (r_dar + f_step(r_size)) : r_dar;
  assign w_rd_data   = f_extract(ibus.ibus_di, r_sar[1:0], r_size);
  assign w_start_bad = f_misaligned(i_src_addr[1:0], i_size) |
                       f_misaligned(i_dst_addr[1:0], i_size);
  assign w_unused_ok = i_ce_f;

  // Transfer FSM together with all registered bus and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_sar        <= 32'd0;
      r_dar        <= 32'd0;
      r_cnt        <= {CNT_W{1'b0}};
      r_size       <= 2'b00;
      r_src_inc    <= 1'b0;
      r_dst_inc    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_a          <= 32'd0;
      r_do         <= 32'd0;
      r_ba         <= 4'd0;
      r_we         <= 1'b0;
      r_req        <= 1'b0;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_addr_err   <= 1'b0;
      r_aborted    <= 1'b0;
    end else if (i_ce_r) begin
      case (r_state)
        ST_IDLE: begin
          r_abort_pend <= 1'b0;
          if (i_start) begin
            r_sar     <= i_src_addr;
            r_dar     <= i_dst_addr;
            r_cnt     <= i_count;
            r_size    <= i_size;
            r_src_inc <= i_src_inc;
            r_dst_inc <= i_dst_inc;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (w_start_bad) begin
              r_addr_err <= 1'b1;
            end else begin
              r_addr_err <= 1'b0;
              r_state    <= ST_RD;
              r_active   <= 1'b1;
              r_req      <= 1'b1;
              r_we       <= 1'b0;
              r_a        <= i_src_addr;
              r_ba       <= f_lane(i_src_addr[1:0], i_size);
            end
          end
        end
        ST_RD: begin
          if (i_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_xfer) begin
            if (w_abort_now) begin
              r_state      <= ST_IDLE;
              r_req        <= 1'b0;
              r_active     <= 1'b0;
              r_aborted    <= 1'b1;
              r_abort_pend <= 1'b0;
            end else begin
              r_state <= ST_WR;
              r_do    <= f_replicate(w_rd_data, r_size);
              r_we    <= 1'b1;
              r_a     <= r_dar;
              r_ba    <= f_lane(r_dar[1:0], r_size);
            end
          end
        end
        ST_WR: begin
          if (i_abort) begin
            r_abort_pend <= 1'b1;
          end
          if (w_xfer) begin
            r_sar <= w_sar_next;
            r_dar <= w_dar_next;
            r_cnt <= r_cnt - CNT_ONE;
            if (w_abort_now) begin
              r_state      <= ST_IDLE;
              r_req        <= 1'b0;
              r_active     <= 1'b0;
              r_aborted    <= 1'b1;
              r_abort_pend <= 1'b0;
            end else if (w_last) begin
              r_state  <= ST_IDLE;
              r_req    <= 1'b0;
              r_active <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state <= ST_RD;
              r_we    <= 1'b0;
              r_a     <= w_sar_next;
              r_ba    <= f_lane(w_sar_next[1:0], r_size);
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_req    <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign ibus.ibus_a   = r_a;
  assign ibus.ibus_do  = r_do;
  assign ibus.ibus_ba  = r_ba;
  assign ibus.ibus_we  = r_we;
  assign ibus.ibus_req = r_req;
  assign o_active      = r_active;
  assign o_done        = r_done;
  assign o_addr_err    = r_addr_err;
  assign o_aborted     = r_aborted;
  assign o_irq         = i_ie & (r_done | r_addr_err);

endmodule

// File: tb/tb_sh7604_ibus_xfer_master.sv
// Scoreboard bench for the IBUS block-copy master: stimulus pushes expected
// bus accesses, a monitor pops and compares on every completed access.
module tb_sh7604_ibus_xfer_master;
  logic        clk;
  logic        rst;
  logic        ce_r;
  logic        ce_f;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic        sinc;
  logic        dinc;
  logic [1:0]  size;
  logic [23:0] count;
  logic        ie;
  logic        abort;
  logic [31:0] di;
  logic        busy;
  logic        active, done, addr_err, aborted, irq;

  sh7604_ibus_xfer_master_if ifc();
  assign ifc.ibus_di   = di;
  assign ifc.ibus_busy = busy;

  sh7604_ibus_xfer_master #(.CNT_W(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce_r(ce_r), .i_ce_f(ce_f), .i_start(start),
    .i_src_addr(src), .i_dst_addr(dst), .i_src_inc(sinc), .i_dst_inc(dinc),
    .i_size(size), .i_count(count), .i_ie(ie), .i_abort(abort),
    .ibus(ifc.master),
    .o_active(active), .o_done(done), .o_addr_err(addr_err),
    .o_aborted(aborted), .o_irq(irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  ba;
    logic [31:0] d;
  } acc_t;

  acc_t exp_q[$];
  int   n_vec;
  int   n_miss;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [3:0] ba,
                      input logic [31:0] d);
    acc_t e;
    e.we = we; e.a = a; e.ba = ba; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic start_go(input logic [31:0] s, input logic [31:0] d, input logic [23:0] c,
                          input logic [1:0] sz, input logic si, input logic dn);
    src = s; dst = d; count = c; size = sz; sinc = si; dinc = dn;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (active && k < 200) begin
      tick(1);
      k++;
    end
    if (active) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got active=1 want active=0", nm);
    end
  endtask

  // Monitor: every access that completes on this edge is checked against the queue.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      if (!rst && ce_r && ifc.ibus_req && !busy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_access: got we=%0b a=%h ba=%b do=%h want none",
                   ifc.ibus_we, ifc.ibus_a, ifc.ibus_ba, ifc.ibus_do);
        end else begin
          e = exp_q.pop_front();
          if (ifc.ibus_we !== e.we || ifc.ibus_a !== e.a || ifc.ibus_ba !== e.ba ||
              (e.we && ifc.ibus_do !== e.d)) begin
            n_miss++;
            $display("FAIL access: got we=%0b a=%h ba=%b do=%h want we=%0b a=%h ba=%b do=%h",
                     ifc.ibus_we, ifc.ibus_a, ifc.ibus_ba, ifc.ibus_do,
                     e.we, e.a, e.ba, e.d);
          end
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; ce_r = 1'b1; ce_f = 1'b0; start = 1'b0; abort = 1'b0;
    src = 32'd0; dst = 32'd0; sinc = 1'b1; dinc = 1'b1; size = 2'b10;
    count = 24'd0; ie = 1'b1; di = 32'd0; busy = 1'b0;
    tick(2);
    chk("rst_req", 32'(ifc.ibus_req), 32'd0);
    chk("rst_a", ifc.ibus_a, 32'd0);
    chk("rst_do", ifc.ibus_do, 32'd0);
    chk("rst_ba", 32'(ifc.ibus_ba), 32'd0);
    chk("rst_we", 32'(ifc.ibus_we), 32'd0);
    chk("rst_flags", {27'd0, active, done, addr_err, aborted, irq}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Long copy, 3 transfers, both incrementing.
    di = 32'h11223344;
    push(1'b0, 32'h06000000, 4'b1111, 32'd0);
    push(1'b1, 32'h06001000, 4'b1111, 32'h11223344);
    push(1'b0, 32'h06000004, 4'b1111, 32'd0);
    push(1'b1, 32'h06001004, 4'b1111, 32'h11223344);
    push(1'b0, 32'h06000008, 4'b1111, 32'd0);
    push(1'b1, 32'h06001008, 4'b1111, 32'h11223344);
    start_go(32'h06000000, 32'h06001000, 24'd3, 2'b10, 1'b1, 1'b1);
    wait_idle("long");
    chk("long_q", 32'(exp_q.size()), 32'd0);
    chk("long_done", 32'(done), 32'd1);
    chk("long_irq", 32'(irq), 32'd1);
    chk("long_aborted", 32'(aborted), 32'd0);

    // Byte copy, IE off so IRQ stays low.
    ie = 1'b0;
    di = 32'hAABBCCDD;
    push(1'b0, 32'hFFFFFF43, 4'b0001, 32'd0);
    push(1'b1, 32'h06000002, 4'b0010, 32'hDDDDDDDD);
    start_go(32'hFFFFFF43, 32'h06000002, 24'd1, 2'b00, 1'b1, 1'b1);
    wait_idle("byte");
    chk("byte_q", 32'(exp_q.size()), 32'd0);
    chk("byte_done", 32'(done), 32'd1);
    chk("byte_irq_off", 32'(irq), 32'd0);
    ie = 1'b1;

    // Word read stalled for 5 CE_R; data only valid on the non-busy edge.
    busy = 1'b1;
    di = 32'hDEADBEEF;
    push(1'b0, 32'h06000002, 4'b0011, 32'd0);
    push(1'b1, 32'h06000010, 4'b1100, 32'h33443344);
    start_go(32'h06000002, 32'h06000010, 24'd1, 2'b01, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(ifc.ibus_req), 32'd1);
      chk("stall_a", ifc.ibus_a, 32'h06000002);
      chk("stall_ba", 32'(ifc.ibus_ba), 32'h3);
      tick(1);
    end
    di = 32'h11223344;
    busy = 1'b0;
    wait_idle("stall");
    chk("stall_q", 32'(exp_q.size()), 32'd0);
    chk("stall_done", 32'(done), 32'd1);

    // Misaligned long source: error flag, no bus activity.
    start_go(32'h06000002, 32'h06001000, 24'd1, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("mis_req", 32'(ifc.ibus_req), 32'd0);
      chk("mis_active", 32'(active), 32'd0);
      tick(1);
    end
    chk("mis_err", 32'(addr_err), 32'd1);
    chk("mis_done", 32'(done), 32'd0);
    chk("mis_irq", 32'(irq), 32'd1);

    // Abort during the second write while the responder stalls.
    di = 32'h01020304;
    push(1'b0, 32'h00000100, 4'b1111, 32'd0);
    push(1'b1, 32'h00000200, 4'b1111, 32'h01020304);
    push(1'b0, 32'h00000104, 4'b1111, 32'd0);
    push(1'b1, 32'h00000204, 4'b1111, 32'h01020304);
    start_go(32'h00000100, 32'h00000200, 24'd10, 2'b10, 1'b1, 1'b1);
    begin
      int k;
      k = 0;
      while (!(ifc.ibus_we && ifc.ibus_a == 32'h00000204) && k < 50) begin
        tick(1);
        k++;
      end
    end
    chk("abort_reach_wr2", {31'd0, ifc.ibus_we}, 32'd1);
    busy = 1'b1;
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    chk("abort_hold_req", 32'(ifc.ibus_req), 32'd1);
    busy = 1'b0;
    wait_idle("abort");
    chk("abort_q", 32'(exp_q.size()), 32'd0);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_irq", 32'(irq), 32'd0);
    chk("abort_addr_err", 32'(addr_err), 32'd0);

    // Reset in the middle of a stalled read, then a clean restart.
    busy = 1'b1;
    start_go(32'h00000300, 32'h00000400, 24'd2, 2'b10, 1'b1, 1'b1);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("mrst_req", 32'(ifc.ibus_req), 32'd0);
    chk("mrst_a", ifc.ibus_a, 32'd0);
    chk("mrst_flags", {27'd0, active, done, addr_err, aborted, irq}, 32'd0);
    rst = 1'b0;
    busy = 1'b0;
    di = 32'h5A5AA5A5;
    push(1'b0, 32'h00000500, 4'b1111, 32'd0);
    push(1'b1, 32'h00000600, 4'b1111, 32'h5A5AA5A5);
    start_go(32'h00000500, 32'h00000600, 24'd1, 2'b10, 1'b1, 1'b1);
    wait_idle("restart");
    chk("restart_q", 32'(exp_q.size()), 32'd0);
    chk("restart_done", 32'(done), 32'd1);

    // CE_R gating, then fixed-source byte copy.
    ce_r = 1'b0;
    di = 32'h12345678;
    src = 32'h00001000; dst = 32'h00002003; count = 24'd2; size = 2'b00;
    sinc = 1'b0; dinc = 1'b1;
    start = 1'b1;
    tick(3);
    chk("ce_active", 32'(active), 32'd0);
    chk("ce_req", 32'(ifc.ibus_req), 32'd0);
    push(1'b0, 32'h00001000, 4'b1000, 32'd0);
    push(1'b1, 32'h00002003, 4'b0001, 32'h12121212);
    push(1'b0, 32'h00001000, 4'b1000, 32'd0);
    push(1'b1, 32'h00002004, 4'b1000, 32'h12121212);
    ce_r = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle("fixed");
    chk("fixed_q", 32'(exp_q.size()), 32'd0);
    chk("fixed_done", 32'(done), 32'd1);

    // Address wrap; START and ABORT together in IDLE: START wins.
    di = 32'hCAFEF00D;
    push(1'b0, 32'hFFFFFFFC, 4'b1111, 32'd0);
    push(1'b1, 32'h00000010, 4'b1111, 32'hCAFEF00D);
    push(1'b0, 32'h00000000, 4'b1111, 32'd0);
    push(1'b1, 32'h00000014, 4'b1111, 32'hCAFEF00D);
    abort = 1'b1;
    start_go(32'hFFFFFFFC, 32'h00000010, 24'd2, 2'b10, 1'b1, 1'b1);
    abort = 1'b0;
    wait_idle("wrap");
    chk("wrap_q", 32'(exp_q.size()), 32'd0);
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_aborted", 32'(aborted), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
